// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(parameter int AW = 64, parameter int DW = 64);
  logic          i_req_valid;
  logic          i_req_ready;
  logic [AW-1:0] i_req_addr;
  logic          i_resp_valid;
  logic [DW-1:0] i_resp_data;
  logic            d_req_valid;
  logic            d_req_ready;
  logic [AW-1:0]   d_req_addr;
  logic            d_req_wen;
  logic [DW-1:0]   d_req_wdata;
  logic [DW/8-1:0] d_req_wmask;
  logic            d_resp_valid;
  logic [DW-1:0]   d_resp_data;
  logic            m_req_valid;
  logic            m_req_ready;
  logic [AW-1:0]   m_req_addr;
  logic            m_req_wen;
  logic [DW-1:0]   m_req_wdata;
  logic [DW/8-1:0] m_req_wmask;
  logic            m_resp_valid;
  logic [DW-1:0]   m_resp_data;
  modport slave (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_resp_valid, i_resp_data,
    input  d_req_valid, d_req_addr, d_req_wen, d_req_wdata, d_req_wmask,
    output d_req_ready, d_resp_valid, d_resp_data,
    output m_req_valid, m_req_addr, m_req_wen, m_req_wdata, m_req_wmask,
    input  m_req_ready, m_resp_valid, m_resp_data
  );
  modport master (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_resp_valid, i_resp_data,
    output d_req_valid, d_req_addr, d_req_wen, d_req_wdata, d_req_wmask,
    input  d_req_ready, d_resp_valid, d_resp_data,
    input  m_req_valid, m_req_addr, m_req_wen, m_req_wdata, m_req_wmask,
    output m_req_ready, m_resp_valid, m_resp_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between I fetch and D load/store, one transaction in flight
// ARB_RR_EN selects round-robin arbitration; otherwise D has fixed priority with a starvation guard for I.
module mem_port_arbiter #(
  parameter int AW         = 64,
  parameter int DW         = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic              busy,
  output logic              owner_d
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t          state_q, state_d;
  logic            owner_q;
  logic [AW-1:0]   addr_q;
  logic            wen_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] wmask_q;
  logic            pick_d, grant_d, grant_i, m_valid, i_resp, d_resp;
`ifdef ARB_RR_EN
  assign pick_d = bus.d_req_valid && !(bus.i_req_valid && owner_q);
`else
  localparam int SW = $clog2(STARVE_MAX + 2);
  logic [SW-1:0] starve_q;
  logic          starved;
  assign starved = (STARVE_MAX != 0) && (starve_q == SW'(STARVE_MAX)) && bus.i_req_valid;
  assign pick_d  = bus.d_req_valid && !starved;
  // count D grants that left I waiting, saturating; any other grant clears it
  always_ff @(posedge clk or negedge rst)
    if (!rst) starve_q <= '0;
    else if (grant_d || grant_i) starve_q <= (grant_d && bus.i_req_valid) ? starve_q + SW'(starve_q != SW'(STARVE_MAX)) : '0;
`endif
  // state register; reset drops any in-flight transaction
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  // arbitration in IDLE, request presentation in REQ, response routing in WAIT
  always_comb begin
    state_d = state_q;
    grant_d = 1'b0;
    grant_i = 1'b0;
    m_valid = 1'b0;
    i_resp  = 1'b0;
    d_resp  = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = rst && pick_d;
        grant_i = rst && !pick_d && bus.i_req_valid;
        state_d = (grant_d || grant_i) ? REQ : IDLE;
      end
      REQ: begin
        m_valid = 1'b1;
        state_d = bus.m_req_ready ? WAIT : REQ;
      end
      WAIT: begin
        i_resp  = bus.m_resp_valid && !owner_q;
        d_resp  = bus.m_resp_valid && owner_q;
        state_d = bus.m_resp_valid ? IDLE : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  // latch the winner's request; I never writes
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      owner_q <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (grant_d || grant_i) begin
      owner_q <= grant_d;
      addr_q  <= grant_d ? bus.d_req_addr : bus.i_req_addr;
      wen_q   <= grant_d && bus.d_req_wen;
      wdata_q <= grant_d ? bus.d_req_wdata : '0;
      wmask_q <= grant_d ? bus.d_req_wmask : '0;
    end
  assign bus.i_req_ready  = grant_i;
  assign bus.d_req_ready  = grant_d;
  assign bus.m_req_valid  = m_valid;
  assign bus.m_req_addr   = addr_q;
  assign bus.m_req_wen    = wen_q;
  assign bus.m_req_wdata  = wdata_q;
  assign bus.m_req_wmask  = wmask_q;
  assign bus.i_resp_valid = i_resp;
  assign bus.i_resp_data  = bus.m_resp_data;
  assign bus.d_resp_valid = d_resp;
  assign bus.d_resp_data  = bus.m_resp_data;
  assign busy             = state_q != IDLE;
  assign owner_d          = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the shared memory port arbiter
module tb_mem_port_arbiter;
  typedef struct packed {
    logic        d;
    logic        chk_data;
    logic [63:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, owner_d;
  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;
  mem_port_arbiter_if #(.AW(64), .DW(64)) bus ();
  mem_port_arbiter #(.AW(64), .DW(64), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .busy(busy), .owner_d(owner_d)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
  // response monitor: every pulse must match the oldest expected response
  always @(negedge clk) begin
    if (bus.i_resp_valid || bus.d_resp_valid) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_resp: got i=%0b d=%0b, required no response", bus.i_resp_valid, bus.d_resp_valid);
      end else begin
        e = sb.pop_front();
        if (bus.d_resp_valid !== e.d || bus.i_resp_valid !== !e.d) begin
          fails++;
          $display("FAIL resp_side: got i=%0b d=%0b, required d=%0b", bus.i_resp_valid, bus.d_resp_valid, e.d);
        end else if (e.chk_data && (e.d ? bus.d_resp_data : bus.i_resp_data) !== e.data) begin
          fails++;
          $display("FAIL resp_data: got %h, required %h", e.d ? bus.d_resp_data : bus.i_resp_data, e.data);
        end
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs;
    bus.i_req_valid = 0; bus.i_req_addr = '0;
    bus.d_req_valid = 0; bus.d_req_addr = '0; bus.d_req_wen = 0;
    bus.d_req_wdata = '0; bus.d_req_wmask = '0;
    bus.m_req_ready = 0; bus.m_resp_valid = 0; bus.m_resp_data = '0;
  endtask
  task automatic apply_reset;
    rst = 0;
    sb.delete();
    tick();
    tick();
    rst = 1;
  endtask
  task automatic test_reset;
    idle_inputs();
    bus.i_req_valid = 1;
    bus.d_req_valid = 1;
    bus.m_req_ready = 1;
    tick();
    tick();
    checks++;
    if ({bus.i_req_ready, bus.d_req_ready} !== 2'b00) begin
      fails++; $display("FAIL reset_ready: got %b, required 00", {bus.i_req_ready, bus.d_req_ready});
    end
    checks++;
    if ({bus.m_req_valid, busy, owner_d} !== 3'b000) begin
      fails++; $display("FAIL reset_state: got mvalid/busy/owner=%b, required 000", {bus.m_req_valid, busy, owner_d});
    end
    checks++;
    if ({bus.m_req_addr, bus.m_req_wen, bus.m_req_wdata, bus.m_req_wmask} !== '0) begin
      fails++; $display("FAIL reset_fields: got addr=%h wen=%b, required 0", bus.m_req_addr, bus.m_req_wen);
    end
    idle_inputs();
    rst = 1;
    tick();
  endtask
  task automatic test_i_read;
    tick();
    bus.i_req_valid = 1; bus.i_req_addr = 64'h8000_0000;
    bus.m_req_ready = 1; bus.m_resp_valid = 1; bus.m_resp_data = 64'h0000_0013_0000_0093;
    #1;
    checks++;
    if ({bus.i_req_ready, bus.d_req_ready} !== 2'b10) begin
      fails++; $display("FAIL iread_accept: got i/d ready=%b, required 10", {bus.i_req_ready, bus.d_req_ready});
    end
    sb.push_back('{d: 1'b0, chk_data: 1'b1, data: 64'h0000_0013_0000_0093});
    tick();
    bus.i_req_valid = 0; bus.i_req_addr = '0;
    #1;
    checks++;
    if ({bus.m_req_valid, bus.m_req_addr, bus.m_req_wen, bus.m_req_wmask} !== {1'b1, 64'h8000_0000, 1'b0, 8'h00}) begin
      fails++; $display("FAIL iread_mreq: got v=%b addr=%h wen=%b mask=%h, required 1 80000000 0 00", bus.m_req_valid, bus.m_req_addr, bus.m_req_wen, bus.m_req_wmask);
    end
    tick();
    checks++;
    if ({bus.i_resp_valid, bus.d_resp_valid} !== 2'b10) begin
      fails++; $display("FAIL iread_resp_n2: got i/d resp=%b, required 10", {bus.i_resp_valid, bus.d_resp_valid});
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL iread_idle_n3: got busy=%b, required 0", busy);
    end
    bus.m_resp_valid = 0;
  endtask
  task automatic test_d_write;
    tick();
    bus.d_req_valid = 1; bus.d_req_addr = 64'h8000_1000; bus.d_req_wen = 1;
    bus.d_req_wdata = 64'hDEAD_BEEF; bus.d_req_wmask = 8'h0F;
    bus.m_req_ready = 0; bus.m_resp_valid = 0; bus.m_resp_data = 64'h1234;
    #1;
    checks++;
    if ({bus.i_req_ready, bus.d_req_ready} !== 2'b01) begin
      fails++; $display("FAIL dwrite_accept: got i/d ready=%b, required 01", {bus.i_req_ready, bus.d_req_ready});
    end
    sb.push_back('{d: 1'b1, chk_data: 1'b0, data: '0});
    tick();
    bus.d_req_valid = 0; bus.d_req_addr = 64'h5555; bus.d_req_wdata = '1; bus.d_req_wmask = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      bus.m_req_ready = (k == 3);
      #1;
      checks++;
      if ({bus.m_req_valid, bus.m_req_addr, bus.m_req_wen, bus.m_req_wdata, bus.m_req_wmask} !==
          {1'b1, 64'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F}) begin
        fails++; $display("FAIL dwrite_req_cycle%0d: got v=%b addr=%h wen=%b wdata=%h mask=%h, required 1 80001000 1 deadbeef 0f", k, bus.m_req_valid, bus.m_req_addr, bus.m_req_wen, bus.m_req_wdata, bus.m_req_wmask);
      end
      tick();
    end
    bus.m_req_ready = 0;
    #1;
    checks++;
    if ({bus.m_req_valid, bus.d_resp_valid, busy} !== 3'b001) begin
      fails++; $display("FAIL dwrite_wait: got mvalid/dresp/busy=%b, required 001", {bus.m_req_valid, bus.d_resp_valid, busy});
    end
    tick();
    bus.m_resp_valid = 1;
    #1;
    checks++;
    if ({bus.d_resp_valid, owner_d} !== 2'b11) begin
      fails++; $display("FAIL dwrite_ack: got dresp/owner=%b, required 11", {bus.d_resp_valid, owner_d});
    end
    tick();
    bus.m_resp_valid = 0;
    #1;
    checks++;
    if ({bus.d_resp_valid, busy} !== 2'b00) begin
      fails++; $display("FAIL dwrite_done: got dresp/busy=%b, required 00", {bus.d_resp_valid, busy});
    end
    bus.d_req_wen = 0; bus.d_req_wdata = '0; bus.d_req_wmask = '0; bus.d_req_addr = '0;
  endtask
  task automatic test_arbitration;
    logic [9:0] order;
    int g = 0;
`ifdef ARB_RR_EN
    order = 10'b01_0101_0101;
`else
    order = 10'b01_1110_1111;
`endif
    idle_inputs();
    apply_reset();
    bus.i_req_valid = 1; bus.i_req_addr = 64'h100;
    bus.d_req_valid = 1; bus.d_req_addr = 64'h200;
    bus.m_req_ready = 1; bus.m_resp_valid = 1; bus.m_resp_data = 64'hABCD_0001;
    #1;
    for (int c = 0; c < 60 && g < 10; c++) begin
      if (bus.i_req_ready && bus.d_req_ready) begin
        checks++; fails++;
        $display("FAIL arb_both_ready: got both ready at grant %0d, required at most one", g);
      end else if (bus.i_req_ready || bus.d_req_ready) begin
        checks++;
        if (bus.d_req_ready !== order[g]) begin
          fails++; $display("FAIL arb_grant%0d: got d=%b, required d=%b", g, bus.d_req_ready, order[g]);
        end
        sb.push_back('{d: order[g], chk_data: 1'b1, data: 64'hABCD_0001});
        g++;
      end
      tick();
    end
    checks++;
    if (g != 10) begin
      fails++; $display("FAIL arb_timeout: got %0d grants, required 10", g);
    end
    bus.i_req_valid = 0; bus.d_req_valid = 0;
    tick(); tick(); tick();
    bus.m_resp_valid = 0;
    checks++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL arb_drain: got %0d pending, required 0", sb.size());
    end
  endtask
  task automatic test_wait_blocks_d;
    tick();
    bus.i_req_valid = 1; bus.i_req_addr = 64'h300;
    bus.m_req_ready = 1; bus.m_resp_valid = 0; bus.m_resp_data = 64'h7777;
    #1;
    checks++;
    if (bus.i_req_ready !== 1'b1) begin
      fails++; $display("FAIL blk_i_accept: got %b, required 1", bus.i_req_ready);
    end
    sb.push_back('{d: 1'b0, chk_data: 1'b1, data: 64'h7777});
    tick();
    bus.i_req_valid = 0;
    tick();
    bus.d_req_valid = 1; bus.d_req_addr = 64'h400;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({bus.d_req_ready, bus.d_resp_valid} !== 2'b00) begin
        fails++; $display("FAIL blk_wait%0d: got dready/dresp=%b, required 00", k, {bus.d_req_ready, bus.d_resp_valid});
      end
      tick();
    end
    bus.m_resp_valid = 1;
    #1;
    checks++;
    if ({bus.i_resp_valid, bus.d_resp_valid, bus.d_req_ready} !== 3'b100) begin
      fails++; $display("FAIL blk_route: got iresp/dresp/dready=%b, required 100", {bus.i_resp_valid, bus.d_resp_valid, bus.d_req_ready});
    end
    tick();
    bus.m_resp_valid = 0;
    #1;
    checks++;
    if (bus.d_req_ready !== 1'b1) begin
      fails++; $display("FAIL blk_d_accept: got %b, required 1", bus.d_req_ready);
    end
    sb.push_back('{d: 1'b1, chk_data: 1'b1, data: 64'h8888});
    tick();
    bus.d_req_valid = 0;
    tick();
    bus.m_resp_valid = 1; bus.m_resp_data = 64'h8888;
    tick();
    bus.m_resp_valid = 0;
    checks++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL blk_drain: got %0d pending, required 0", sb.size());
    end
  endtask
  task automatic test_reset_in_wait;
    tick();
    bus.i_req_valid = 1; bus.i_req_addr = 64'h500;
    bus.m_req_ready = 1; bus.m_resp_valid = 0; bus.m_resp_data = 64'h9999;
    tick();
    bus.i_req_valid = 0;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL rstw_inflight: got busy=%b, required 1", busy);
    end
    rst = 0;
    bus.m_resp_valid = 1;
    #1;
    checks++;
    if ({busy, bus.m_req_valid, bus.i_resp_valid, bus.d_resp_valid} !== 4'b0000) begin
      fails++; $display("FAIL rstw_async: got busy/mvalid/iresp/dresp=%b, required 0000", {busy, bus.m_req_valid, bus.i_resp_valid, bus.d_resp_valid});
    end
    tick();
    rst = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({busy, bus.m_req_valid, bus.i_resp_valid, bus.d_resp_valid} !== 4'b0000) begin
        fails++; $display("FAIL rstw_late_resp%0d: got busy/mvalid/iresp/dresp=%b, required 0000", k, {busy, bus.m_req_valid, bus.i_resp_valid, bus.d_resp_valid});
      end
    end
    bus.m_resp_valid = 0;
  endtask
  task automatic test_idle_resp;
    bus.m_resp_valid = 1; bus.m_resp_data = 64'h4242;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({busy, bus.i_resp_valid, bus.d_resp_valid} !== 3'b000) begin
        fails++; $display("FAIL idle_resp%0d: got busy/iresp/dresp=%b, required 000", k, {busy, bus.i_resp_valid, bus.d_resp_valid});
      end
    end
    bus.m_resp_valid = 0;
  endtask
  initial begin
    idle_inputs();
    test_reset();
    test_i_read();
    test_d_write();
    test_arbitration();
    test_wait_blocks_d();
    test_reset_in_wait();
    test_idle_resp();
    tick();
    checks++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL final_drain: got %0d pending, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
